wide_add_seq: RTL and testbench

Multi-cycle sequencer that performs a WORDS×32-bit add or subtract by streaming one 32-bit word per cycle, least significant word first, through a single `kogger_stone` 32-bit adder instance, chaining the carry through a register. It sits between a control master (start/busy/done handshake) and the shared Kogge-Stone datapath. Wide arithmetic therefore costs one adder plus operand/result registers instead of a WORDS×32-bit carry tree.

---
 rtl/wide_add_seq.sv | 145 ++++++++++++++
 tb/tb_wide_add_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_seq.sv
// Multi-word add/subtract sequencer that streams one 32-bit word per cycle,
// least significant word first, through a shared Kogge-Stone adder.

module kogger_stone (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [32:0] sum,
   output logic        cout
);
   // g_l[k]/p_l[k] hold group generate/propagate after k prefix levels.
   // The carry-in is folded into bit 0's generate, so the final g_l[5][i] is the carry out of bit i.
   logic [31:0] g_l [6];
   logic [31:0] p_l [5];

   assign p_l[0] = a ^ b;
   assign g_l[0] = {a[31:1] & b[31:1], (a[0] & b[0]) | ((a[0] ^ b[0]) & cin)};

   for (genvar lv = 0; lv < 5; lv++) begin : g_level
      localparam int D = 1 << lv;
      assign g_l[lv+1] = g_l[lv] | (p_l[lv] & {g_l[lv][31-D:0], {D{1'b0}}});
      if (lv < 4) begin : g_prop
         assign p_l[lv+1] = p_l[lv] & {p_l[lv][31-D:0], {D{1'b1}}};
      end
   end

   assign sum  = {g_l[5][31], p_l[0] ^ {g_l[5][30:0], cin}};
   assign cout = g_l[5][31];
endmodule

module wide_add_seq #(
   parameter int unsigned WORDS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                sub,
   input  logic                cin,
   input  logic [32*WORDS-1:0] op_a,
   input  logic [32*WORDS-1:0] op_b,
   output logic                busy,
   output logic                done,
   output logic [32*WORDS-1:0] result,
   output logic                cout,
   output logic                ovf
);
   localparam int W  = 32 * WORDS;
   localparam int IW = $clog2(WORDS);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e         state_q, state_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [W-1:0]   result_q, result_d;
   logic           carry_q, carry_d;
   logic           cout_q, cout_d;
   logic           ovf_q, ovf_d;

   logic [31:0]    a_word, b_word;
   logic [32:0]    sum;
   logic           adder_cout_unused;
   logic           last_word;

   assign a_word    = a_q[int'(idx_q)*32 +: 32];
   assign b_word    = b_q[int'(idx_q)*32 +: 32];
   assign last_word = (idx_q == IW'(WORDS - 1));

   kogger_stone u_adder (
      .a    (a_word),
      .b    (b_word),
      .cin  (carry_q),
      .sum  (sum),
      .cout (adder_cout_unused)
   );

   // NOTE: every _d is defaulted to its _q first so no path through the case leaves a latch.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RUN;
               idx_d   = '0;
               a_d     = op_a;
               // Subtraction is A + ~B + 1, so the inverted B and forced carry are set up here.
               b_d     = sub ? ~op_b : op_b;
               carry_d = sub | cin;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            result_d[int'(idx_q)*32 +: 32] = sum[31:0];
            carry_d = sum[32];
            idx_d   = idx_q + IW'(1);
            if (last_word) begin
               cout_d  = sum[32];
               ovf_d   = (a_word[31] == b_word[31]) && (sum[31] != a_word[31]);
               idx_d   = '0;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   // NOTE: operand and carry registers are reset too, so nothing in the block ever starts from X.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy   = (state_q == S_RUN);
   assign done   = (state_q == S_DONE);
   assign result = result_q;
   assign cout   = cout_q;
   assign ovf    = ovf_q;
endmodule

// File: tb/tb_wide_add_seq.sv
// Directed-vector bench for wide_add_seq (WORDS=4): latency, carry/borrow,
// overflow, ignored start, back-to-back throughput and mid-run reset.

module tb_wide_add_seq;
   localparam int WORDS = 4;
   localparam int W     = 32 * WORDS;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         sub;
   logic         cin;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;

   int checks = 0;
   int errors = 0;

   wide_add_seq #(.WORDS(WORDS)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .sub    (sub),
      .cin    (cin),
      .op_a   (op_a),
      .op_b   (op_b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .ovf    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Waits (bounded) for done after the accepting edge; returns cycles from E0.
   task automatic wait_done(output int lat);
      bit seen;
      seen = 1'b0;
      lat  = 0;
      while (!seen && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         if (done) seen = 1'b1;
      end
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic ci,
                         input logic [W-1:0] exp_r, input logic exp_c, input logic exp_o);
      int lat;
      op_a  = a;
      op_b  = b;
      sub   = s;
      cin   = ci;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, "_busy"}, W'(busy), W'(1));
      wait_done(lat);
      check({tag, "_lat"}, W'(lat), W'(WORDS));
      check({tag, "_res"}, result, exp_r);
      check({tag, "_cout"}, W'(cout), W'(exp_c));
      check({tag, "_ovf"}, W'(ovf), W'(exp_o));
      @(posedge clk);
      #1;
      check({tag, "_pulse"}, W'(done), W'(0));
   endtask

   logic [W-1:0] all_ones;
   logic [W-1:0] max_pos;
   logic [W-1:0] min_neg;
   logic [W-1:0] low3;

   initial begin
      int lat;
      int n;
      int cnt;
      int exp_pos [3];
      logic [W-1:0] exp_res [3];

      all_ones = {W{1'b1}};
      max_pos  = {1'b0, {(W-1){1'b1}}};
      min_neg  = {1'b1, {(W-1){1'b0}}};
      low3     = {{32{1'b0}}, {96{1'b1}}};

      rst_n = 1'b0;
      start = 1'b0;
      sub   = 1'b0;
      cin   = 1'b0;
      op_a  = '0;
      op_b  = '0;
      #3;
      check("rst_busy", W'(busy), W'(0));
      check("rst_done", W'(done), W'(0));
      check("rst_result", result, W'(0));
      check("rst_cout_ovf", W'({cout, ovf}), W'(0));
      #9 rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_op("add_small", W'(3), W'(1), 1'b0, 1'b0, W'(4), 1'b0, 1'b0);
      run_op("ripple", all_ones, W'(0), 1'b0, 1'b1, W'(0), 1'b1, 1'b0);
      run_op("sub_borrow", W'(5), W'(7), 1'b1, 1'b0, all_ones - W'(1), 1'b0, 1'b0);
      run_op("sub_pos", W'(7), W'(5), 1'b1, 1'b1, W'(2), 1'b1, 1'b0);
      run_op("ovf_pos", max_pos, W'(1), 1'b0, 1'b0, min_neg, 1'b0, 1'b1);
      run_op("ovf_neg", min_neg, W'(1), 1'b1, 1'b0, max_pos, 1'b1, 1'b1);
      run_op("word_carry", low3, W'(1), 1'b0, 1'b0, {{31{1'b0}}, 1'b1, {96{1'b0}}}, 1'b0, 1'b0);

      // start pulsed mid-run with different operands must be ignored
      op_a  = W'(3);
      op_b  = W'(1);
      sub   = 1'b0;
      cin   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      op_a  = W'(100);
      op_b  = W'(200);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(lat);
      check("ign_lat", W'(lat), W'(WORDS - 2));
      check("ign_res", result, W'(4));
      @(posedge clk);
      #1;
      check("ign_idle", W'({busy, done}), W'(0));

      // start held high: done every WORDS+1 cycles, operands re-captured each time
      exp_pos = '{4, 9, 14};
      exp_res = '{W'(30), W'(1001), W'(1001)};
      op_a  = W'(10);
      op_b  = W'(20);
      start = 1'b1;
      n     = 0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            if (n < 3) begin
               check($sformatf("b2b_pos%0d", n), W'(k), W'(exp_pos[n]));
               check($sformatf("b2b_res%0d", n), result, exp_res[n]);
            end
            n++;
            if (n == 1) begin
               op_a = W'(1000);
               op_b = W'(1);
            end
         end
      end
      start = 1'b0;
      check("b2b_count", W'(n), W'(3));

      // reset while idx=2 abandons the operation
      run_op("pre_rst", W'(7), W'(5), 1'b1, 1'b0, W'(2), 1'b1, 1'b0);
      op_a  = W'(50);
      op_b  = W'(60);
      sub   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", W'(busy), W'(0));
      check("mid_rst_done", W'(done), W'(0));
      check("mid_rst_res", result, W'(0));
      check("mid_rst_cout_ovf", W'({cout, ovf}), W'(0));
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         if (done || busy) cnt++;
      end
      check("post_rst_quiet", W'(cnt), W'(0));
      run_op("post_rst", W'(50), W'(60), 1'b0, 1'b1, W'(111), 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
